// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key strobes into short/long/double
// click pulses (plus optional auto-repeat ticks) for the control logic.
// Ports: clk, rst_n (async, active low); key_stable (change strobe),
//   key_flag (0 = pressed); short_pulse, long_pulse, double_pulse,
//   repeat_pulse (one-cycle, registered); key_busy (gesture in progress).
// Build option: define KEY_REPEAT_EN to enable auto-repeat while held.
module key_event_decoder #(
   parameter int unsigned LONG_CNT = 200000,
   parameter int unsigned DBL_CNT  = 60000,
   parameter int unsigned REP_CNT  = 40000,
   parameter int unsigned CNT_W    = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_stable,
   input  logic key_flag,
   output logic short_pulse,
   output logic long_pulse,
   output logic double_pulse,
   output logic repeat_pulse,
   output logic key_busy
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] DBL_END  = CNT_W'(DBL_CNT - 1);

   // Every terminal count must fit the counter and be reachable.
   if (LONG_CNT < 2 || DBL_CNT < 2 || REP_CNT < 2 ||
       LONG_CNT > (1 << CNT_W) || DBL_CNT > (1 << CNT_W) ||
       REP_CNT > (1 << CNT_W)) begin : g_bad_param
      $error("key_event_decoder: counter parameters out of range");
   end

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             short_nxt;
   logic             long_nxt;
   logic             dbl_nxt;
   logic             rep_nxt;
   logic             press_ev;
   logic             rel_ev;

   assign press_ev = key_stable & ~key_flag;
   assign rel_ev   = key_stable &  key_flag;

   always_comb begin
      state_nxt = state;
      short_nxt = 1'b0;
      long_nxt  = 1'b0;
      dbl_nxt   = 1'b0;
      rep_nxt   = 1'b0;
      // Key events are tested before timeouts so they win a tie.
      unique case (state)
         IDLE: begin
            if (press_ev) state_nxt = PRESS1;
         end
         PRESS1: begin
            if (rel_ev) begin
               state_nxt = WAIT2;
            end else if (cnt == LONG_END) begin
               state_nxt = LONG_HOLD;
               long_nxt  = 1'b1;
            end
         end
         WAIT2: begin
            if (press_ev) begin
               state_nxt = PRESS2;
            end else if (cnt == DBL_END) begin
               state_nxt = IDLE;
               short_nxt = 1'b1;
            end
         end
         PRESS2: begin
            if (rel_ev) begin
               state_nxt = IDLE;
               dbl_nxt   = 1'b1;
            end else if (cnt == LONG_END) begin
               state_nxt = LONG_HOLD;
               long_nxt  = 1'b1;
            end
         end
         LONG_HOLD: begin
            if (rel_ev) begin
               state_nxt = IDLE;
            end
`ifdef KEY_REPEAT_EN
            else if (cnt == CNT_W'(REP_CNT - 1)) begin
               rep_nxt = 1'b1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A repeat tick restarts the period without leaving LONG_HOLD.
   always_comb begin
      cnt_nxt = '0;
      if (state_nxt == state && !rep_nxt && state != IDLE)
         cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         double_pulse <= 1'b0;
         key_busy     <= 1'b0;
`ifdef KEY_REPEAT_EN
         repeat_pulse <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         short_pulse  <= short_nxt;
         long_pulse   <= long_nxt;
         double_pulse <= dbl_nxt;
         key_busy     <= (state_nxt != IDLE);
`ifdef KEY_REPEAT_EN
         repeat_pulse <= rep_nxt;
`endif
      end
   end

`ifndef KEY_REPEAT_EN
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed checks of key gesture classification.
// Runs with LONG_CNT=20, DBL_CNT=8, REP_CNT=5.
module tb_key_event_decoder;

   localparam int unsigned LONG_CNT = 20;
   localparam int unsigned DBL_CNT  = 8;
   localparam int unsigned REP_CNT  = 5;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic key_stable = 1'b0;
   logic key_flag   = 1'b1;
   logic short_pulse;
   logic long_pulse;
   logic double_pulse;
   logic repeat_pulse;
   logic key_busy;

   key_event_decoder #(
      .LONG_CNT(LONG_CNT),
      .DBL_CNT (DBL_CNT),
      .REP_CNT (REP_CNT),
      .CNT_W   (18)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_stable  (key_stable),
      .key_flag    (key_flag),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .double_pulse(double_pulse),
      .repeat_pulse(repeat_pulse),
      .key_busy    (key_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t = 0;
   int n_short, n_long, n_dbl, n_rep;
   int t_short, t_long, t_dbl;
   int rep_t [8];
   logic sp_busy, sp_prev_busy, prev_busy;
   int tp, tr, exp_rep;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0;
      t_short = -1; t_long = -1; t_dbl = -1;
      for (int i = 0; i < 8; i++) rep_t[i] = -1;
   endtask

   // One clock: drive strobe, pass the edge, sample 1 ns later.
   task automatic cyc(input logic s);
      key_stable = s;
      @(posedge clk);
      #1;
      key_stable = 1'b0;
      t++;
      if (short_pulse) begin
         n_short++; t_short = t;
         sp_busy = key_busy; sp_prev_busy = prev_busy;
      end
      if (long_pulse) begin n_long++; t_long = t; end
      if (double_pulse) begin n_dbl++; t_dbl = t; end
      if (repeat_pulse) begin
         if (n_rep < 8) rep_t[n_rep] = t;
         n_rep++;
      end
      chk("one_pulse_max",
          32'($countones({short_pulse, long_pulse, double_pulse,
                          repeat_pulse}) <= 1), 1);
      prev_busy = key_busy;
   endtask

   task automatic press();
      key_flag = 1'b0;
      cyc(1'b1);
   endtask

   task automatic release_key();
      key_flag = 1'b1;
      cyc(1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   initial begin
      prev_busy = 1'b0;
      clr();
      // Reset state
      #12;
      chk("rst_outputs", {27'd0, short_pulse, long_pulse, double_pulse,
                          repeat_pulse, key_busy}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Short press: pulse DBL_CNT+1 after release, busy drops with it
      clr();
      press();
      chk("busy_after_press", key_busy, 1);
      idle(4);
      release_key();
      tr = t;
      idle(15);
      chk("short_cnt", n_short, 1);
      chk("short_latency", t_short - tr + 1, 9);
      chk("short_busy_at_pulse", sp_busy, 0);
      chk("short_busy_before", sp_prev_busy, 1);
      chk("short_other", n_long + n_dbl + n_rep, 0);

      // Long press held 30 cycles
      clr();
      press();
      tp = t;
      idle(29);
      release_key();
      chk("long_busy_rel", key_busy, 0);
      idle(10);
      chk("long_cnt", n_long, 1);
      chk("long_latency", t_long - tp + 1, 21);
      chk("long_other", n_short + n_dbl, 0);
`ifdef KEY_REPEAT_EN
      exp_rep = 1;
`else
      exp_rep = 0;
`endif
      chk("long_rep_cnt", n_rep, exp_rep);

      // Double click
      clr();
      press();
      idle(2);
      release_key();
      idle(3);
      press();
      idle(2);
      release_key();
      tr = t;
      idle(15);
      chk("dbl_cnt", n_dbl, 1);
      chk("dbl_latency", t_dbl - tr, 0);
      chk("dbl_other", n_short + n_long + n_rep, 0);

      // Release on PRESS1 terminal cycle, press on WAIT2 terminal cycle
      clr();
      press();
      idle(19);
      release_key();
      chk("edge_no_long", n_long, 0);
      chk("edge_busy_w2", key_busy, 1);
      idle(7);
      press();
      chk("edge_no_short", n_short, 0);
      chk("edge_busy_p2", key_busy, 1);
      idle(2);
      release_key();
      idle(10);
      chk("edge_dbl", n_dbl, 1);
      chk("edge_other", n_short + n_long + n_rep, 0);

      // Hold for auto-repeat
      clr();
      press();
      tp = t;
      idle(41);
      release_key();
      idle(5);
      chk("hold_long_latency", t_long - tp + 1, 21);
`ifdef KEY_REPEAT_EN
      chk("hold_rep_cnt", n_rep, 4);
      chk("hold_rep0", rep_t[0] - tp + 1, 26);
      chk("hold_rep1", rep_t[1] - tp + 1, 31);
      chk("hold_rep2", rep_t[2] - tp + 1, 36);
      chk("hold_rep3", rep_t[3] - tp + 1, 41);
`else
      chk("hold_rep_cnt", n_rep, 0);
`endif

      // Reset during PRESS2
      clr();
      press();
      idle(2);
      release_key();
      idle(2);
      press();
      idle(3);
      chk("p2_busy_pre_rst", key_busy, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {27'd0, short_pulse, long_pulse,
                              double_pulse, repeat_pulse, key_busy}, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_outputs", {27'd0, short_pulse, long_pulse,
                               double_pulse, repeat_pulse, key_busy}, 0);
      rst_n = 1'b1;
      key_flag = 1'b1;
      clr();
      idle(30);
      chk("post_rst_pulses", n_short + n_long + n_dbl + n_rep, 0);
      chk("post_rst_busy", key_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
